// File: rtl/lift_pkg.sv
// lift_pkg: shared motion encodings and controller state type for the lift controller
package lift_pkg;
  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] STAY = 2'b10;
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_e;
endpackage

// File: rtl/lift_dwell_timer.sv
// lift_dwell_timer: loadable counter that flags done when it reaches limit, then wraps to zero
module lift_dwell_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);
  logic [WIDTH-1:0] cnt;
  assign done = cnt == limit;
  always_ff @(posedge clk)
    if (rst || load) cnt <= '0;
    else if (en) cnt <= done ? '0 : cnt + 1'b1;
endmodule

// File: rtl/lift_ctrl_fsm.sv
// lift_ctrl_fsm: elevator car controller with per-floor travel time and door dwell
module lift_ctrl_fsm
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 8,
  localparam int FLOOR_W = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [FLOOR_W-1:0] req_floor,
  output logic               req_ready,
  output logic [1:0]         dout,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               door_open,
  output logic               arrived,
  output logic               req_err
);
  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  state_e state;
  logic [1:0] dir;
  logic [FLOOR_W-1:0] target;
  logic [FLOOR_W-1:0] next_floor;
  logic hs, bad, go_move, enter_door, move_done, door_done;
  assign req_ready = state == IDLE && !rst;
  assign hs = req_valid && req_ready;
  assign bad = {1'b0, req_floor} >= (FLOOR_W + 1)'(NUM_FLOORS);
  assign go_move = hs && !bad && req_floor != cur_floor;
  assign next_floor = dir == UP ? cur_floor + 1'b1 : cur_floor - 1'b1;
  assign enter_door = (hs && !bad && req_floor == cur_floor) ||
                      (state == MOVE && move_done && next_floor == target);
  assign dout = state == MOVE ? dir : STAY;
  assign door_open = state == DOOR;
  lift_dwell_timer #(.WIDTH(MW)) u_move_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (hs),
    .en    (state == MOVE),
    .limit (MW'(MOVE_CYCLES - 1)),
    .done  (move_done)
  );
  lift_dwell_timer #(.WIDTH(DW)) u_door_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (enter_door),
    .en    (state == DOOR),
    .limit (DW'(DOOR_CYCLES - 1)),
    .done  (door_done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      dir <= UP;
      target <= '0;
      cur_floor <= '0;
      arrived <= 1'b0;
      req_err <= 1'b0;
    end else begin
      arrived <= enter_door;
      req_err <= hs && bad;
      if (go_move) begin
        target <= req_floor;
        dir <= req_floor > cur_floor ? UP : DOWN;
        state <= MOVE;
      end
      if (state == MOVE && move_done) cur_floor <= next_floor;
      if (enter_door) state <= DOOR;
      if (state == DOOR && door_done) state <= IDLE;
    end
endmodule

// File: tb/tb_lift_ctrl_fsm.sv
// tb_lift_ctrl_fsm: directed and random stimulus checked against a trip-timeline reference model
module tb_lift_ctrl_fsm;
  import lift_pkg::*;
  localparam int NF = 5;
  localparam int MC = 4;
  localparam int DC = 8;
  localparam int FW = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic req_ready;
  logic [1:0] dout;
  logic [FW-1:0] cur_floor;
  logic door_open, arrived, req_err;
  lift_ctrl_fsm #(.NUM_FLOORS(NF), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_floor (req_floor),
    .req_ready (req_ready),
    .dout      (dout),
    .cur_floor (cur_floor),
    .door_open (door_open),
    .arrived   (arrived),
    .req_err   (req_err)
  );
  always #5 clk = ~clk;
  int c = 0;
  int npass = 0;
  int ntot = 0;
  bit busy = 0;
  bit in_rst = 1;
  int t_acc = 0;
  int s_fl = 0;
  int t_fl = 0;
  int cur = 0;
  int err_t = -10;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s cycle %0d: got %0d expected %0d", tag, c, obs, exp);
  endtask
  task automatic expect_now();
    int d, mv_end, dr_end;
    logic [31:0] e_rdy, e_dout, e_fl, e_door, e_arr;
    e_rdy = 1; e_dout = 32'(STAY); e_fl = cur; e_door = 0; e_arr = 0;
    if (busy) begin
      d = t_fl > s_fl ? t_fl - s_fl : s_fl - t_fl;
      mv_end = t_acc + d * MC;
      dr_end = mv_end + DC;
      if (c > dr_end) begin
        busy = 0;
        cur = t_fl;
        e_fl = cur;
      end else if (c <= mv_end) begin
        e_rdy = 0;
        e_dout = t_fl > s_fl ? 32'(UP) : 32'(DOWN);
        e_fl = t_fl > s_fl ? s_fl + (c - t_acc - 1) / MC : s_fl - (c - t_acc - 1) / MC;
      end else begin
        e_rdy = 0;
        e_fl = t_fl;
        e_door = 1;
        e_arr = (c == mv_end + 1) ? 1 : 0;
      end
    end
    if (in_rst) e_rdy = 0;
    chk("req_ready", req_ready, e_rdy);
    chk("dout", dout, e_dout);
    chk("cur_floor", cur_floor, e_fl);
    chk("door_open", door_open, e_door);
    chk("arrived", arrived, e_arr);
    chk("req_err", req_err, (c == err_t + 1) ? 1 : 0);
  endtask
  task automatic tick(input bit v, input int f, input bit r);
    expect_now();
    rst = r;
    req_valid = v;
    req_floor = FW'(f);
    if (r) begin
      busy = 0;
      cur = 0;
      err_t = -10;
    end else if (v && !busy) begin
      if (f >= NF) err_t = c;
      else begin
        busy = 1;
        t_acc = c;
        s_fl = cur;
        t_fl = f;
      end
    end
    in_rst = r;
    @(posedge clk);
    c++;
    @(negedge clk);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick(0, 0, 0);
    tick(0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick(0, 0, 0);
    tick(1, 3, 0);
    wait_idle();
    tick(1, 3, 0);
    wait_idle();
    tick(1, 0, 0);
    wait_idle();
    tick(1, 0, 0);
    wait_idle();
    tick(1, 3, 0);
    wait_idle();
    tick(1, 1, 0);
    wait_idle();
    for (int i = 0; i < 40; i++) tick(1, 2, 0);
    wait_idle();
    tick(1, 6, 0);
    tick(1, 7, 0);
    tick(1, 5, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(1, 4, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 1500; i++)
      tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom_range(0, 149) == 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
